// File: rtl/spi_slave_transmitter.sv
// ============================================================================
// Module   : spi_slave_transmitter
// Brief    : SPI mode-0 slave transmitter; shifts a held word out MSB-first on
//            miso while the external master drives sck/ss (clk-oversampled).
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_slave_transmitter #(
    parameter int DATA_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_LENGTH-1:0] data,
    input  logic                   load,
    input  logic                   sck,
    input  logic                   ss,
    output logic                   miso,
    output logic                   busy,
    output logic                   full,
    output logic                   done,
    output logic                   underrun
);

    localparam int CW = $clog2(DATA_LENGTH) + 1;
    localparam logic [CW-1:0] c_FRAME_LEN = CW'(DATA_LENGTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [2:0]             r_sck_sync, r_ss_sync;
    logic [DATA_LENGTH-1:0] r_shift, w_shift_nxt;
    logic [DATA_LENGTH-1:0] r_hold, w_hold_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic                   r_full, w_full_nxt;
    logic                   r_miso, w_miso_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_underrun, w_underrun_nxt;
    logic                   w_start, w_xfer, w_load_ok;
    logic                   w_sck_rise, w_sck_fall, w_ss_rise, w_ss_fall;

    // Sync flops clear to 0 so a reset with ss already low cannot fake an ss_fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_sync <= '0;
            r_ss_sync  <= '0;
        end else begin
            r_sck_sync <= {r_sck_sync[1:0], sck};
            r_ss_sync  <= {r_ss_sync[1:0], ss};
        end
    end

    assign w_sck_rise =  r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall = ~r_sck_sync[1] &  r_sck_sync[2];
    assign w_ss_rise  =  r_ss_sync[1]  & ~r_ss_sync[2];
    assign w_ss_fall  = ~r_ss_sync[1]  &  r_ss_sync[2];

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_miso_nxt     = r_miso;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_underrun_nxt = 1'b0;
        w_start        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                w_miso_nxt = 1'b0;
                if (w_ss_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_start     = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_ss_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_miso_nxt  = 1'b0;
                end else if (w_sck_rise) begin
                    if (r_cnt < c_FRAME_LEN) begin
                        w_cnt_nxt  = r_cnt + 1'b1;
                        w_done_nxt = (r_cnt + 1'b1 == c_FRAME_LEN);
                    end
                end else if (w_sck_fall) begin
                    if (r_cnt < c_FRAME_LEN) begin
                        w_shift_nxt = {r_shift[DATA_LENGTH-2:0], 1'b0};
                        w_miso_nxt  = r_shift[DATA_LENGTH-2];
                    end else begin
                        // Continuous frame: ss still low, start the next word.
                        w_cnt_nxt = '0;
                        w_start   = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_start) begin
            if (r_full) begin
                w_shift_nxt = r_hold;
                w_miso_nxt  = r_hold[DATA_LENGTH-1];
            end else begin
                w_shift_nxt    = '0;
                w_miso_nxt     = 1'b0;
                w_underrun_nxt = 1'b1;
            end
        end
    end

    // A load is taken while the holder is being emptied into the shifter.
    assign w_xfer    = w_start & r_full;
    assign w_load_ok = load & (~r_full | w_xfer);

    always_comb begin
        w_hold_nxt = r_hold;
        w_full_nxt = r_full;
        if (w_load_ok) begin
            w_hold_nxt = data;
            w_full_nxt = 1'b1;
        end else if (w_xfer) begin
            w_full_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_hold     <= '0;
            r_cnt      <= '0;
            r_full     <= 1'b0;
            r_miso     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_hold     <= w_hold_nxt;
            r_cnt      <= w_cnt_nxt;
            r_full     <= w_full_nxt;
            r_miso     <= w_miso_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    assign miso     = r_miso;
    assign busy     = r_busy;
    assign full     = r_full;
    assign done     = r_done;
    assign underrun = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_transmitter.sv
// ============================================================================
// Module   : tb_spi_slave_transmitter
// Brief    : Directed self-checking bench for spi_slave_transmitter (mode 0).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_spi_slave_transmitter;

    localparam int HALF = 50;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       load;
    logic       sck;
    logic       ss;
    logic       miso;
    logic       busy;
    logic       full;
    logic       done;
    logic       underrun;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_total = 0;
    int urun_total = 0;

    spi_slave_transmitter #(.DATA_LENGTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .load     (load),
        .sck      (sck),
        .ss       (ss),
        .miso     (miso),
        .busy     (busy),
        .full     (full),
        .done     (done),
        .underrun (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done)     done_total++;
        if (underrun) urun_total++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] w);
        data = w;
        load = 1'b1;
        wait_clk(1);
        load = 1'b0;
        wait_clk(1);
    endtask

    // Master side: sample miso just before each rising sck, as a mode-0 master would.
    task automatic shift_bits(input int n, output logic [15:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            if (i != 0) begin
                sck = 1'b0;
                wait_clk(HALF);
            end
            got = {got[14:0], miso};
            sck = 1'b1;
            wait_clk(HALF);
        end
    endtask

    task automatic start_frame();
        ss = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic end_frame();
        ss = 1'b1;
        wait_clk(10);
        sck = 1'b0;
        wait_clk(10);
    endtask

    task automatic test_reset();
        n_cmp++; if (miso !== 1'b0)     begin n_fail++; $display("FAIL reset_miso got %b want 0", miso); end
        n_cmp++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (full !== 1'b0)     begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
        n_cmp++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got %b want 0", underrun); end
    endtask

    task automatic test_basic();
        logic [15:0] got;
        int d0;
        do_load(8'hA5);
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL basic_full_set got %b want 1", full); end
        d0 = done_total;
        start_frame();
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL basic_full_clr got %b want 0", full); end
        shift_bits(8, got);
        n_cmp++; if (got[7:0] !== 8'hA5) begin n_fail++; $display("FAIL basic_data got %h want a5", got[7:0]); end
        n_cmp++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL basic_done got %0d want 1", done_total - d0); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_hold got %b want 1", busy); end
        end_frame();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_drop got %b want 0", busy); end
        n_cmp++; if (miso !== 1'b0) begin n_fail++; $display("FAIL basic_miso_idle got %b want 0", miso); end
    endtask

    task automatic test_underrun();
        logic [15:0] got;
        int d0, u0;
        d0 = done_total;
        u0 = urun_total;
        start_frame();
        shift_bits(8, got);
        end_frame();
        n_cmp++; if (urun_total - u0 !== 1) begin n_fail++; $display("FAIL urun_pulse got %0d want 1", urun_total - u0); end
        n_cmp++; if (got[7:0] !== 8'h00) begin n_fail++; $display("FAIL urun_data got %h want 00", got[7:0]); end
        n_cmp++; if (done_total - d0 !== 1) begin n_fail++; $display("FAIL urun_done got %0d want 1", done_total - d0); end
    endtask

    task automatic test_ignore_full();
        logic [15:0] got;
        do_load(8'h3C);
        do_load(8'hFF);
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL ign_full got %b want 1", full); end
        start_frame();
        shift_bits(8, got);
        end_frame();
        n_cmp++; if (got[7:0] !== 8'h3C) begin n_fail++; $display("FAIL ign_data got %h want 3c", got[7:0]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got;
        int d0, u0;
        do_load(8'h81);
        d0 = done_total;
        u0 = urun_total;
        start_frame();
        do_load(8'h7E);
        shift_bits(16, got);
        end_frame();
        n_cmp++; if (got !== 16'h817E) begin n_fail++; $display("FAIL b2b_data got %h want 817e", got); end
        n_cmp++; if (done_total - d0 !== 2) begin n_fail++; $display("FAIL b2b_done got %0d want 2", done_total - d0); end
        n_cmp++; if (urun_total - u0 !== 0) begin n_fail++; $display("FAIL b2b_urun got %0d want 0", urun_total - u0); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL b2b_full got %b want 0", full); end
    endtask

    task automatic test_abort();
        logic [15:0] got;
        int d0;
        do_load(8'h5A);
        d0 = done_total;
        start_frame();
        do_load(8'hC3);
        shift_bits(3, got);
        n_cmp++; if (got[2:0] !== 3'b010) begin n_fail++; $display("FAIL abort_bits got %b want 010", got[2:0]); end
        end_frame();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_cmp++; if (miso !== 1'b0) begin n_fail++; $display("FAIL abort_miso got %b want 0", miso); end
        n_cmp++; if (done_total - d0 !== 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", done_total - d0); end
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL abort_full got %b want 1", full); end
        start_frame();
        shift_bits(8, got);
        end_frame();
        n_cmp++; if (got[7:0] !== 8'hC3) begin n_fail++; $display("FAIL abort_next got %h want c3", got[7:0]); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        int d0, u0;
        do_load(8'h99);
        start_frame();
        do_load(8'h66);
        shift_bits(3, got);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        n_cmp++; if ({miso, busy, full, done, underrun} !== 5'b0) begin
            n_fail++; $display("FAIL rstmid_outs got %b want 00000", {miso, busy, full, done, underrun});
        end
        d0 = done_total;
        for (int i = 0; i < 6; i++) begin
            sck = ~sck;
            wait_clk(10);
        end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        n_cmp++; if (done_total - d0 !== 0) begin n_fail++; $display("FAIL rstmid_done got %0d want 0", done_total - d0); end
        end_frame();
        u0 = urun_total;
        start_frame();
        shift_bits(8, got);
        end_frame();
        n_cmp++; if (urun_total - u0 !== 1) begin n_fail++; $display("FAIL rstmid_urun got %0d want 1", urun_total - u0); end
        n_cmp++; if (got[7:0] !== 8'h00) begin n_fail++; $display("FAIL rstmid_data got %h want 00", got[7:0]); end
    endtask

    initial begin
        rst  = 1'b1;
        data = '0;
        load = 1'b0;
        sck  = 1'b0;
        ss   = 1'b1;
        wait_clk(3);
        rst  = 1'b0;
        wait_clk(5);
        test_reset();
        test_basic();
        test_underrun();
        test_ignore_full();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
